// File: rtl/ques3_pkg.sv
// Shared definitions for the Ques3 control sequencer.
//   - instruction class encodings and field bit positions
//   - sequencer state encoding
//   - ALU opcode constants understood by the Ques3 ALU
//   - decoded-instruction struct produced by ques3_instr_decode
package ques3_pkg;

    localparam int INSTR_W = 32;

    // Instruction field positions; imm occupies [IMM_W-1:0] and overlaps rs2.
    localparam int CLS_HI = 31;
    localparam int CLS_LO = 30;
    localparam int OP_HI  = 29;
    localparam int OP_LO  = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS1_HI = 21;
    localparam int RS1_LO = 17;
    localparam int RS2_HI = 16;
    localparam int RS2_LO = 12;

    // ALU opcodes as decoded by the Ques3 ALU.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'b00,
        CLS_LOADI = 2'b01,
        CLS_SKIPZ = 2'b10,
        CLS_NOP   = 2'b11
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_WB     = 2'b11
    } state_e;

    typedef struct packed {
        instr_class_e cls;
        logic [2:0]   op;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
    } decoded_t;

endpackage

// File: rtl/ques3_sequencer_if.sv
// Bus between an instruction source / Ques3 datapath and the sequencer.
//   Instr, Instr_valid, Instr_ready : instruction handshake
//   zero                            : ALU zero fed back from Ques3
//   Data_in, Read_Addr_1/2, Write_Addr, Write_Enable, Mux_ctrl, opcode
//                                   : Ques3 control inputs
//   Zero_flag, Retired, Busy        : sequencer status
// master = instruction source / datapath side, slave = sequencer.
interface ques3_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      Instr;
    logic             Instr_valid;
    logic             Instr_ready;
    logic             zero;
    logic [31:0]      Data_in;
    logic [4:0]       Read_Addr_1;
    logic [4:0]       Read_Addr_2;
    logic [4:0]       Write_Addr;
    logic             Write_Enable;
    logic             Mux_ctrl;
    logic [2:0]       opcode;
    logic             Zero_flag;
    logic [CNT_W-1:0] Retired;
    logic             Busy;

    modport master (
        output Instr, Instr_valid, zero,
        input  Instr_ready, Data_in, Read_Addr_1, Read_Addr_2, Write_Addr,
               Write_Enable, Mux_ctrl, opcode, Zero_flag, Retired, Busy
    );

    modport slave (
        input  Instr, Instr_valid, zero,
        output Instr_ready, Data_in, Read_Addr_1, Read_Addr_2, Write_Addr,
               Write_Enable, Mux_ctrl, opcode, Zero_flag, Retired, Busy
    );
endinterface

// File: rtl/ques3_instr_decode.sv
// Purely combinational field extraction and class decode of one instruction.
//   i_instr   : 32-bit instruction word
//   o_dec     : class, opcode, rd, rs1, rs2
//   o_imm_ext : imm[IMM_W-1:0] zero-extended to 32 bits
module ques3_instr_decode
    import ques3_pkg::*;
#(
    parameter int IMM_W = 13
) (
    input  logic [INSTR_W-1:0] i_instr,
    output decoded_t           o_dec,
    output logic [31:0]        o_imm_ext
);

    always_comb begin
        o_dec.cls = instr_class_e'(i_instr[CLS_HI:CLS_LO]);
        o_dec.op  = i_instr[OP_HI:OP_LO];
        o_dec.rd  = i_instr[RD_HI:RD_LO];
        o_dec.rs1 = i_instr[RS1_HI:RS1_LO];
        o_dec.rs2 = i_instr[RS2_HI:RS2_LO];
        o_imm_ext = 32'(i_instr[IMM_W-1:0]);
    end

endmodule

// File: rtl/ques3_sequencer.sv
// Control-side driver for the Ques3 datapath. Accepts one instruction per
// IDLE->DECODE->EXEC->WB pass and drives every Ques3 control input.
//   Clock   : system clock, rising edge
//   Reset_n : synchronous active-low reset
//   bus     : handshake, Ques3 controls, zero feedback and status (slave side)
module ques3_sequencer
    import ques3_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int IMM_W = 13
) (
    input logic              Clock,
    input logic              Reset_n,
    ques3_sequencer_if.slave bus
);

    state_e           r_state;
    state_e           w_next;
    logic             w_ready;
    logic [31:0]      r_instr;
    decoded_t         w_dec;
    logic [31:0]      w_imm;
    logic [4:0]       r_ra1;
    logic [4:0]       r_ra2;
    logic [4:0]       r_wa;
    logic [2:0]       r_op;
    logic             r_mux;
    logic [31:0]      r_data;
    logic             r_we;
    logic             r_zflag;
    logic             r_skip_pending;
    logic             r_skip_cur;     // the instruction in flight is being skipped
    logic [CNT_W-1:0] r_retired;

    ques3_instr_decode #(.IMM_W(IMM_W)) u_decode (
        .i_instr   (r_instr),
        .o_dec     (w_dec),
        .o_imm_ext (w_imm)
    );

    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!Reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a
        // signal unassigned and infers a latch.
        w_next  = r_state;
        w_ready = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.Instr_valid) w_next = ST_DECODE;
            end
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC:   w_next = ST_WB;
            ST_WB:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_instr        <= '0;
            r_ra1          <= '0;
            r_ra2          <= '0;
            r_wa           <= '0;
            r_op           <= '0;
            r_mux          <= 1'b0;
            r_data         <= '0;
            r_we           <= 1'b0;
            r_zflag        <= 1'b0;
            r_skip_pending <= 1'b0;
            r_skip_cur     <= 1'b0;
            r_retired      <= '0;
        end else begin
            // Write strobe is a single pulse covering only the WB cycle.
            r_we <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.Instr_valid) begin
                        r_instr    <= bus.Instr;
                        r_skip_cur <= r_skip_pending;
                    end
                end
                ST_DECODE: begin
                    // Registered at the end of DECODE so the datapath sees
                    // stable addresses for the whole of EXEC and WB.
                    r_ra1 <= w_dec.rs1;
                    r_ra2 <= w_dec.rs2;
                    r_wa  <= w_dec.rd;
                    r_op  <= w_dec.op;
                    if (w_dec.cls == CLS_ALU) begin
                        r_mux  <= 1'b1;
                        r_data <= '0;
                    end else if (w_dec.cls == CLS_LOADI) begin
                        r_mux  <= 1'b0;
                        r_data <= w_imm;
                    end
                end
                ST_EXEC: begin
                    // A skipped instruction has no side effects at all,
                    // which also keeps a skipped SKIPZ from re-arming.
                    if (!r_skip_cur) begin
                        if (w_dec.cls == CLS_ALU) r_zflag <= bus.zero;
                        if (w_dec.cls == CLS_SKIPZ && r_zflag) r_skip_pending <= 1'b1;
                        if (w_dec.cls == CLS_ALU || w_dec.cls == CLS_LOADI) r_we <= 1'b1;
                    end
                end
                ST_WB: begin
                    r_retired <= r_retired + CNT_W'(1);
                    if (r_skip_cur) r_skip_pending <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Instr_ready  = w_ready;
    assign bus.Busy         = (r_state != ST_IDLE);
    assign bus.Read_Addr_1  = r_ra1;
    assign bus.Read_Addr_2  = r_ra2;
    assign bus.Write_Addr   = r_wa;
    assign bus.opcode       = r_op;
    assign bus.Mux_ctrl     = r_mux;
    assign bus.Data_in      = r_data;
    assign bus.Write_Enable = r_we;
    assign bus.Zero_flag    = r_zflag;
    assign bus.Retired      = r_retired;

endmodule

// File: doc/ques3_sequencer.md
Name: ques3_sequencer

Overview:
- Control-side driver for the Ques3 datapath (register file + ALU + writeback mux).
- Accepts 32-bit instruction words over a valid/ready handshake, decodes them, and sequences Read_Addr_1/2, opcode, Mux_ctrl, Data_in, Write_Addr and Write_Enable.
- Produces every Ques3 control input itself, so no testbench has to hand-drive them.
- Samples the datapath `zero` output to keep a flag and to support one conditional-skip instruction.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- IMM_W, 13, immediate field width; zero-extended to 32 bits onto Data_in

Ports:
- Clock  input  1  system clock, rising edge
- Reset_n  input  1  synchronous, active-low reset
- Instr  input  32  instruction word
- Instr_valid  input  1  Instr is valid this cycle
- Instr_ready  output  1  sequencer can accept Instr
- zero  input  1  ALU zero output from Ques3
- Data_in  output  32  immediate to Ques3 Data_in
- Read_Addr_1  output  5  register file read port 1
- Read_Addr_2  output  5  register file read port 2
- Write_Addr  output  5  register file write address
- Write_Enable  output  1  register file write strobe
- Mux_ctrl  output  1  writeback select: 0 = Data_in, 1 = ALU result
- opcode  output  3  ALU opcode
- Zero_flag  output  1  last sampled ALU zero
- Retired  output  CNT_W  count of completed instructions
- Busy  output  1  high whenever state != IDLE

Behaviour:
- Instruction format:
  - [31:30] class: 00 ALU, 01 LOADI, 10 SKIPZ, 11 NOP
  - [29:27] opcode
  - [26:22] rd
  - [21:17] rs1
  - [16:12] rs2
  - [IMM_W-1:0] imm (overlaps rs2 for LOADI only)
- States: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE:
  - Instr_ready=1.
  - On Instr_valid&Instr_ready, latch Instr and go to DECODE.
  - Otherwise stay in IDLE.
- DECODE:
  - Drive Read_Addr_1=rs1, Read_Addr_2=rs2, opcode, and Write_Addr=rd.
  - LOADI: Mux_ctrl=0, Data_in=zero-extended imm.
  - ALU: Mux_ctrl=1, Data_in=0.
  - These outputs are registered and held until the next DECODE.
- EXEC:
  - ALU: Zero_flag<=zero, sampled at the end of EXEC (two edges after acceptance).
  - LOADI/NOP/SKIPZ: Zero_flag unchanged.
- WB:
  - ALU or LOADI: Write_Enable=1 for exactly this one cycle; the register file captures on the WB->IDLE edge.
  - Retired increments for every class.
  - Return to IDLE.
- Latency and throughput:
  - Acceptance to Write_Enable high = 3 cycles.
  - Throughput is one instruction per 4 cycles.
- SKIPZ:
  - If Zero_flag=1 at EXEC, set skip_pending.
  - The next accepted instruction then passes through DECODE/EXEC/WB with Write_Enable forced 0 and Zero_flag unchanged.
  - It still counts in Retired, and skip_pending clears at its WB.
  - SKIPZ following a skipped instruction is evaluated normally. A skipped SKIPZ does not arm.
- NOP: no write, no flag change.
- Write_Enable is never high outside WB.
- Write to rd=0 is permitted; there is no hardwired-zero register.
- Instr_valid outside IDLE is ignored, and Instr is not re-sampled.
- Retired wraps modulo 2^CNT_W.
- Reset (Reset_n=0 at a rising edge, from any state, including mid-instruction):
  - state=IDLE, Instr_ready=1.
  - Write_Enable=0, Mux_ctrl=0, opcode=0, Data_in=0.
  - All addresses 0.
  - Zero_flag=0, skip_pending=0, Retired=0.
  - An in-flight instruction is dropped with no write.

Decomposition:
- Shared package ques3_pkg:
  - class encodings (CLS_ALU, CLS_LOADI, CLS_SKIPZ, CLS_NOP)
  - state encoding
  - ALU opcode constants (3'b000 = add, etc., as already used by the ALU)
  - instruction field bit positions
- One natural sub-module, ques3_instr_decode: purely combinational field extraction and class decode.
- FSM, counters and output registers stay in ques3_sequencer.
- The verification top instantiates ques3_sequencer driving Ques3, with `zero` fed back.

Test Plan:
- LOADI rd=0 imm=2, then LOADI rd=1 imm=3 -> Write_Enable pulses with Write_Addr=0/Data_in=2 then 1/3, Mux_ctrl=0; Retired=2.
- After loads, ALU opcode=000 rd=0 rs1=0 rs2=1 -> Read_Addr_1=0, Read_Addr_2=1, Mux_ctrl=1, WE pulse 3 cycles after accept; reg0 reads back 5.
- ALU op producing zero (e.g. subtract reg1-reg1) then SKIPZ, then LOADI rd=2 imm=7 -> Zero_flag=1, LOADI not written (WE stays 0), Retired=3.
- Instr_valid held high continuously with 3 instructions -> Instr_ready high only in IDLE, exactly one accept per 4 cycles, no instruction lost or duplicated.
- Reset_n low during EXEC of an ALU instruction -> no WE pulse, all outputs 0, Retired=0, Instr_ready=1 the cycle after reset releases.
- 2^CNT_W+1 NOPs -> no WE ever, Retired wraps to 1.
